// File: rtl/divisor.sv
// Sequential unsigned restoring divider: one quotient bit per clock, QN+1 cycles per result.
// Turns the accumulated sum from the averaging chain into the averaged sample and remainder.
module divisor #(
    parameter int QN = 50,
    parameter int QD = 20
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [QN-1:0] x,
    input  logic [QD-1:0] d,
    output logic          busy,
    output logic          done,
    output logic [QN-1:0] q,
    output logic [QD-1:0] r,
    output logic          div_zero
);

    localparam int CW = $clog2(QN + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIN
    } state_t;

    state_t        state, nxt;
    logic          load, step, fin;
    logic [QD:0]   rem;
    logic [QN-1:0] dvd;
    logic [QD-1:0] dsr;
    logic [CW-1:0] cnt;
    logic          dz;

    // One restoring iteration: quotient bits enter at the bottom of the dividend register.
    function automatic logic [QD+QN:0] div_step(input logic [QD:0] rem_i,
                                                input logic [QN-1:0] dvd_i,
                                                input logic [QD-1:0] dsr_i);
        logic [QD+1:0] rem_sh;
        logic [QD+1:0] dsr_ext;
        logic          ge;
        logic [QD:0]   rem_o;
        rem_sh  = {rem_i, dvd_i[QN-1]};
        dsr_ext = {2'b00, dsr_i};
        ge      = (rem_sh >= dsr_ext);
        rem_o   = ge ? (QD+1)'(rem_sh - dsr_ext) : rem_sh[QD:0];
        return {rem_o, dvd_i[QN-2:0], ge};
    endfunction

    assign dz   = (dsr == '0);
    assign busy = (state == S_RUN);

    always_ff @(posedge clk) begin
        if (reset_n) state <= S_IDLE;
        else         state <= nxt;
    end

    always_comb begin
        nxt  = state;
        load = 1'b0;
        step = 1'b0;
        fin  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    load = 1'b1;
                    nxt  = S_RUN;
                end
            end
            S_RUN: begin
                step = 1'b1;
                if (cnt == CW'(1)) nxt = S_FIN;
            end
            S_FIN: begin
                fin = 1'b1;
                if (start) begin
                    load = 1'b1;
                    nxt  = S_RUN;
                end else begin
                    nxt = S_IDLE;
                end
            end
            default: nxt = S_IDLE;
        endcase
    end

    // Result registers sample the working registers before a same-cycle reload overwrites them.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            rem      <= '0;
            dvd      <= '0;
            dsr      <= '0;
            cnt      <= '0;
            done     <= 1'b0;
            q        <= '0;
            r        <= '0;
            div_zero <= 1'b0;
        end else begin
            done <= fin;
            if (load) begin
                rem <= '0;
                dvd <= x;
                dsr <= d;
                cnt <= CW'(QN);
            end else if (step) begin
                {rem, dvd} <= div_step(rem, dvd, dsr);
                cnt        <= cnt - CW'(1);
            end
            if (fin) begin
                q        <= dz ? '1 : dvd;
                r        <= dz ? '0 : rem[QD-1:0];
                div_zero <= dz;
            end
        end
    end

endmodule

// File: tb/tb_divisor.sv
// Self-checking bench for divisor: vector table plus handshake/reset sequences,
// with a result scoreboard popped whenever done is seen.
module tb_divisor;

    localparam int QN  = 50;
    localparam int QD  = 20;
    localparam int LAT = QN + 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [QN-1:0] x;
    logic [QD-1:0] d;
    logic          busy, done, div_zero;
    logic [QN-1:0] q;
    logic [QD-1:0] r;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [QN-1:0] q;
        logic [QD-1:0] r;
        logic          dz;
    } res_t;

    typedef struct {
        logic [QN-1:0] x;
        logic [QD-1:0] d;
        logic [QN-1:0] q;
        logic [QD-1:0] r;
        logic          dz;
    } vec_t;

    res_t sb[$];
    vec_t tbl[7];

    divisor #(.QN(QN), .QD(QD)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .x(x), .d(d),
        .busy(busy), .done(done), .q(q), .r(r), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every done must match the oldest outstanding expectation.
    always @(posedge clk) begin
        res_t e;
        #1;
        if (!reset_n && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no result pending");
            end else begin
                e = sb.pop_front();
                chk("q", 64'(q), 64'(e.q));
                chk("r", 64'(r), 64'(e.r));
                chk("div_zero", 64'(div_zero), 64'(e.dz));
            end
        end
    end

    // Drive start for the edge that follows; x/d are scrambled afterwards to prove they were captured.
    task automatic issue(input logic [QN-1:0] xi, input logic [QD-1:0] di, input bit push,
                         input logic [QN-1:0] eq, input logic [QD-1:0] er, input logic edz);
        res_t e;
        start = 1'b1;
        x     = xi;
        d     = di;
        if (push) begin
            e.q = eq; e.r = er; e.dz = edz;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        x     = ~xi;
        d     = di ^ 20'h5a5a5;
    endtask

    task automatic wait_done(output int k);
        k = 0;
        while (k < LAT + 10) begin
            @(posedge clk);
            #2;
            k++;
            if (done) break;
        end
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int k;
        @(negedge clk);
        issue(v.x, v.d, 1'b1, v.q, v.r, v.dz);
        chk({name, "_busy"}, 64'(busy), 64'(1));
        wait_done(k);
        chk({name, "_latency"}, 64'(k), 64'(LAT));
    endtask

    initial begin
        int k;
        logic [QN-1:0] ones;
        logic [QD-1:0] dmax;
        vec_t v;
        ones = '1;
        dmax = '1;

        tbl[0] = '{x: 50'd192,  d: 20'd3, q: 50'd64,  r: 20'd0,  dz: 1'b0};
        tbl[1] = '{x: 50'd100,  d: 20'd7, q: 50'd14,  r: 20'd2,  dz: 1'b0};
        tbl[2] = '{x: ones,     d: 20'd1, q: ones,    r: 20'd0,  dz: 1'b0};
        tbl[3] = '{x: 50'd48,   d: dmax,  q: 50'd0,   r: 20'd48, dz: 1'b0};
        tbl[4] = '{x: 50'd0,    d: 20'd5, q: 50'd0,   r: 20'd0,  dz: 1'b0};
        tbl[5] = '{x: 50'd32,   d: 20'd0, q: ones,    r: 20'd0,  dz: 1'b1};
        tbl[6] = '{x: 50'd1000, d: 20'd9, q: 50'd111, r: 20'd1,  dz: 1'b0};

        reset_n = 1'b1;
        start   = 1'b0;
        x       = '0;
        d       = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_q", 64'(q), 64'(0));
        chk("rst_r", 64'(r), 64'(0));
        chk("rst_dz", 64'(div_zero), 64'(0));
        repeat (10) @(posedge clk);

        for (int i = 0; i < 7; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 4; i++) begin
            v.x  = {18'($urandom), 32'($urandom)};
            v.d  = 20'($urandom_range(1, 20'hfffff));
            v.q  = v.x / 50'(v.d);
            v.r  = 20'(v.x % 50'(v.d));
            v.dz = 1'b0;
            run_vec(v, $sformatf("rnd%0d", i));
        end

        // A start while busy must be ignored: only the first request produces a result.
        @(negedge clk);
        issue(50'd64, 20'd4, 1'b1, 50'd16, 20'd0, 1'b0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        issue(50'd9, 20'd3, 1'b0, '0, '0, 1'b0);
        wait_done(k);
        chk("ignored_start_latency", 64'(k), 64'(LAT - 6));
        repeat (LAT + 5) @(posedge clk);
        #1;
        chk("ignored_start_idle", 64'(busy), 64'(0));
        chk("q_holds", 64'(q), 64'(16));

        // Start asserted in the cycle done is high.
        @(negedge clk);
        issue(50'd100, 20'd7, 1'b1, 50'd14, 20'd2, 1'b0);
        wait_done(k);
        chk("b2b_first_latency", 64'(k), 64'(LAT));
        issue(50'd9, 20'd3, 1'b1, 50'd3, 20'd0, 1'b0);
        chk("b2b_busy", 64'(busy), 64'(1));
        wait_done(k);
        chk("b2b_second_latency", 64'(k), 64'(LAT));

        // Reset in the middle of a division discards it.
        @(negedge clk);
        issue(50'd192, 20'd3, 1'b0, '0, '0, 1'b0);
        repeat (19) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_done", 64'(done), 64'(0));
        chk("midrst_q", 64'(q), 64'(0));
        chk("midrst_r", 64'(r), 64'(0));
        chk("midrst_dz", 64'(div_zero), 64'(0));
        @(negedge clk);
        reset_n = 1'b0;
        repeat (LAT + 10) @(posedge clk);
        run_vec(tbl[0], "post_rst");
        repeat (5) @(posedge clk);
        #3;
        chk("sb_empty", 64'(sb.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/divisor.md
Name: divisor

Overview:
- Sequential unsigned restoring divider that works as the inverse of the sumador accumulator in the coherent-average datapath.
- Takes the wide accumulated sum and divides it by the number of accumulated frames (or any divisor) to produce the averaged sample and its remainder.
- Sits downstream of the sumador/accumulator and upstream of the lock-in output register.
- Uses a one-bit-per-cycle architecture to save DSP/LUT area.

Parameters:
- QN, 50, dividend width in bits (sum width, i.e. Q1+Q2 of the sumador).
- QD, 20, divisor and remainder width in bits.

Ports:
- clk, input, 1, system clock; all logic on rising edge.
- reset_n, input, 1, synchronous, active-high reset: asserted when 1 and sampled on the clk rising edge.
- start, input, 1, one-cycle request; x and d are captured when start=1 and the block is ready.
- x, input, QN, unsigned dividend.
- d, input, QD, unsigned divisor.
- busy, output, 1, high while a division is in progress; start is ignored while busy=1.
- done, output, 1, one-cycle pulse when q, r and div_zero are valid.
- q, output, QN, unsigned quotient; holds its value until the next done.
- r, output, QD, unsigned remainder; holds its value until the next done.
- div_zero, output, 1, set with done when the captured d was 0; holds its value until the next done.

Behaviour:
- Reset: when reset_n=1 at a clk edge, the block enters IDLE. busy=0, done=0, q=0, r=0, div_zero=0, and internal registers are cleared. This applies from any state, including mid-division; the in-flight result is discarded and no done is produced.
- States and transitions:
  - IDLE to RUN: on start=1. Capture x into the dividend shift register and d into the divisor register. Clear the partial remainder (QD+1 bits). Set the iteration counter to QN. Set busy=1 from the next cycle.
  - RUN, each cycle:
    - Shift {partial remainder, dividend} left by 1.
    - Trial = partial remainder − divisor, computed at QD+1 width.
    - If the trial is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
    - Decrement the counter.
    - After QN iterations go to DONE.
  - DONE (exactly one cycle):
    - Register q/r/div_zero and pulse done=1 with busy=0.
    - If start=1 in this cycle, accept a new operation and go to RUN (back-to-back throughput is QN+1 cycles per result). Otherwise go to IDLE.
- Latency: with start sampled at edge T, done=1 in the cycle after edge T+QN+1. That is 51 cycles for the defaults.
- start while busy=1 (RUN) is ignored, and x/d changes during RUN have no effect.
- Divide by zero: latency is unchanged. Results are q = all ones (2^QN−1), r = 0, div_zero=1.
- Arithmetic:
  - Result satisfies x = q·d + r with r < d for d≠0.
  - No rounding.
  - Quotient never overflows because q is QN bits wide.
- Outputs q/r/div_zero change only on the edge that raises done (or on reset).

Test Plan:
- Reset then idle: hold reset_n=1 for 3 cycles, then 0 → busy=0, done=0, q=0, r=0, div_zero=0; no done ever appears without start.
- Basic division:
  - start with x=192, d=3 → done exactly 51 cycles after the start edge, with q=64, r=0, div_zero=0.
  - Then x=100, d=7 → q=14, r=2.
- Extremes:
  - x=2^50−1, d=1 → q=2^50−1, r=0.
  - x=48, d=2^20−1 → q=0, r=48.
  - x=0, d=5 → q=0, r=0.
- Divide by zero: x=32, d=0 → done after 51 cycles, q=2^50−1, r=0, div_zero=1. The next valid operation clears div_zero.
- Handshake:
  - Pulse start with x=64, d=4, then pulse start with x=9, d=3 while busy=1 → single result q=16, r=0.
  - Assert start with x=9, d=3 in the done cycle → busy=1 on the next cycle, and the second done arrives 51 cycles later with q=3, r=0.
- Reset mid-operation: start x=192, d=3, then assert reset_n=1 at cycle 20 → no done; outputs zero. A new start afterwards completes with correct results and full latency.
